// File: rtl/debug_loader.sv
// debug_loader: UART byte stream to pipeline program-load / run-control front end.
// Assembles big-endian 32-bit words into sequential instruction-memory writes,
// then runs the pipeline either freely until halt or one cycle per step command.
module debug_loader #(
  parameter int                 NB_ADDR   = 8,
  parameter int                 NB_DATA   = 32,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFC00_0000
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_halt,
  output logic               o_debug_unit,
  output logic [NB_DATA-1:0] o_inst_load,
  output logic [NB_ADDR-1:0] o_addr_inst_load,
  output logic               o_en_write,
  output logic               o_enable_pipe,
  output logic               o_en_read,
  output logic               o_halted,
  output logic               o_overflow,
  output logic [2:0]         o_state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_STEP  = 3'd4;

  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_CONT = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'

  logic [2:0]         r_state;
  logic [1:0]         r_byte_cnt;
  logic [NB_DATA-1:0] r_word;
  logic [NB_ADDR-1:0] r_addr;
  logic               r_halted;
  logic               r_overflow;

  logic               w_loading;
  logic               w_running;
  logic               w_load_cmd;
  logic               w_byte_in;

  // LOAD and WRITE both own the memory; a byte arriving in WRITE already
  // belongs to the next word, so the assembler keeps accepting there.
  assign w_loading  = (r_state == ST_LOAD) || (r_state == ST_WRITE);
  assign w_running  = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign w_load_cmd = (r_state == ST_IDLE) && i_rx_done && (i_rx_data == CMD_LOAD);
  assign w_byte_in  = w_loading && i_rx_done;

  // Byte assembler: shift in big-endian, restart cleanly on every load command
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r_word     <= '0;
      r_byte_cnt <= 2'd0;
    end else if (w_load_cmd) begin
      r_word     <= '0;
      r_byte_cnt <= 2'd0;
    end else if (w_byte_in) begin
      r_word     <= {r_word[NB_DATA-9:0], i_rx_data};
      r_byte_cnt <= r_byte_cnt + 2'd1;
    end
  end

  // Control FSM with write address and the sticky halted/overflow flags
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_halted   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_rx_done) begin
            if (i_rx_data == CMD_LOAD) begin
              r_state    <= ST_LOAD;
              r_addr     <= '0;
              r_halted   <= 1'b0;
              r_overflow <= 1'b0;
            end else if ((i_rx_data == CMD_CONT) && !r_halted) begin
              r_state <= ST_RUN;
            end else if ((i_rx_data == CMD_STEP) && !r_halted) begin
              r_state <= ST_STEP;
            end
          end
        end
        ST_LOAD: begin
          if (i_rx_done && (r_byte_cnt == 2'd3)) begin
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Halt word ends the program; a full memory without one is flagged.
          if (r_word == HALT_WORD) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
          end else if (&r_addr) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_overflow <= 1'b1;
          end else begin
            r_state <= ST_LOAD;
            r_addr  <= r_addr + 1'b1;
          end
        end
        ST_RUN: begin
          if (i_halt) begin
            r_state  <= ST_IDLE;
            r_halted <= 1'b1;
          end
        end
        ST_STEP: begin
          r_state <= ST_IDLE;
          if (i_halt) begin
            r_halted <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode from registered state only, so no input reaches an output
  // combinationally.
  assign o_debug_unit     = w_loading;
  assign o_en_write       = (r_state == ST_WRITE);
  assign o_inst_load      = (r_state == ST_WRITE) ? r_word : '0;
  assign o_addr_inst_load = r_addr;
  assign o_enable_pipe    = w_running;
  assign o_en_read        = w_running;
  assign o_halted         = r_halted;
  assign o_overflow       = r_overflow;
  assign o_state          = r_state;

endmodule

// File: tb/tb_debug_loader.sv
// Bench for debug_loader (NB_ADDR=2 so memory overflow is reachable quickly).
// Writes are checked against a queue of expected {addr, data} filled as words
// are sent; run/step enables are counted against hand-derived totals.
module tb_debug_loader;

  localparam int          NB_ADDR = 2;
  localparam int          NB_DATA = 32;
  localparam logic [31:0] HALT    = 32'hFC00_0000;

  logic               clock = 1'b0;
  logic               i_reset;
  logic [7:0]         i_rx_data;
  logic               i_rx_done;
  logic               i_halt;
  logic               o_debug_unit;
  logic [NB_DATA-1:0] o_inst_load;
  logic [NB_ADDR-1:0] o_addr_inst_load;
  logic               o_en_write;
  logic               o_enable_pipe;
  logic               o_en_read;
  logic               o_halted;
  logic               o_overflow;
  logic [2:0]         o_state;

  debug_loader #(
    .NB_ADDR   (NB_ADDR),
    .NB_DATA   (NB_DATA),
    .HALT_WORD (HALT)
  ) dut (
    .clock            (clock),
    .i_reset          (i_reset),
    .i_rx_data        (i_rx_data),
    .i_rx_done        (i_rx_done),
    .i_halt           (i_halt),
    .o_debug_unit     (o_debug_unit),
    .o_inst_load      (o_inst_load),
    .o_addr_inst_load (o_addr_inst_load),
    .o_en_write       (o_en_write),
    .o_enable_pipe    (o_enable_pipe),
    .o_en_read        (o_en_read),
    .o_halted         (o_halted),
    .o_overflow       (o_overflow),
    .o_state          (o_state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0]        word;
    logic [NB_ADDR-1:0] addr;
    logic               wr;
  } vec_t;

  typedef struct {
    logic [NB_ADDR-1:0] addr;
    logic [31:0]        data;
  } wr_t;

  vec_t vec [8];
  wr_t  exp_q [$];
  int   total = 0;
  int   bad   = 0;
  int   n_wr  = 0;
  int   n_en  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Sample outputs settled from the previous rising edge.
  task automatic observe();
    wr_t e;
    if (o_en_write) begin
      n_wr++;
      $display("write addr=%0d data=%h", o_addr_inst_load, o_inst_load);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected: got write addr=%0d data=%h, required none",
                 o_addr_inst_load, o_inst_load);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(o_addr_inst_load), 32'(e.addr));
        chk("wr_data", o_inst_load, e.data);
        chk("wr_debug_unit", 32'(o_debug_unit), 32'd1);
      end
    end else begin
      chk("inst_load_idle", o_inst_load, 32'd0);
    end
    if (o_enable_pipe) n_en++;
  endtask

  task automatic tick(input logic done, input logic [7:0] data, input logic halt);
    @(negedge clock);
    observe();
    i_rx_done = done;
    i_rx_data = data;
    i_halt    = halt;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick(1'b1, b, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
  endtask

  task automatic push(input logic [NB_ADDR-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [7:0] b2b [8];
    vec[0] = '{32'h3C01_000A, 2'd0, 1'b1};
    vec[1] = '{32'h3C02_0014, 2'd1, 1'b1};
    vec[2] = '{HALT,          2'd2, 1'b1};
    vec[3] = '{32'h1111_1111, 2'd0, 1'b1};
    vec[4] = '{32'h2222_2222, 2'd1, 1'b1};
    vec[5] = '{32'h3333_3333, 2'd2, 1'b1};
    vec[6] = '{32'h4444_4444, 2'd3, 1'b1};
    vec[7] = '{32'h0102_0304, 2'd0, 1'b0};
    b2b    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    i_reset = 1'b1; i_rx_done = 1'b0; i_rx_data = 8'h00; i_halt = 1'b0;
    repeat (2) @(negedge clock);
    i_reset = 1'b0;

    // Reset state
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_debug_unit", 32'(o_debug_unit), 32'd0);
    chk("rst_en_write", 32'(o_en_write), 32'd0);
    chk("rst_addr", 32'(o_addr_inst_load), 32'd0);
    chk("rst_enable_pipe", 32'(o_enable_pipe), 32'd0);
    chk("rst_en_read", 32'(o_en_read), 32'd0);
    chk("rst_halted", 32'(o_halted), 32'd0);
    chk("rst_overflow", 32'(o_overflow), 32'd0);

    // Load three words ending with the halt word
    send_byte(8'h4C);
    chk("load_state", 32'(o_state), 32'd1);
    chk("load_debug_unit", 32'(o_debug_unit), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (vec[i].wr) push(vec[i].addr, vec[i].word);
      send_word(vec[i].word);
    end
    tick(1'b0, 8'h00, 1'b0);
    chk("load_done_debug_unit", 32'(o_debug_unit), 32'd0);
    chk("load_done_state", 32'(o_state), 32'd0);
    chk("load_writes", 32'(n_wr), 32'd3);

    // Run until halt, ten enabled cycles
    n_en = 0;
    send_byte(8'h43);
    chk("run_state", 32'(o_state), 32'd3);
    chk("run_enable_pipe", 32'(o_enable_pipe), 32'd1);
    chk("run_en_read", 32'(o_en_read), 32'd1);
    repeat (8) tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    chk("run_cycles", 32'(n_en), 32'd10);
    chk("run_halt_enable", 32'(o_enable_pipe), 32'd0);
    chk("run_halted", 32'(o_halted), 32'd1);
    chk("run_halt_state", 32'(o_state), 32'd0);
    send_byte(8'h43);
    repeat (3) tick(1'b0, 8'h00, 1'b0);
    chk("run_after_halt_cycles", 32'(n_en), 32'd10);
    chk("run_after_halt_state", 32'(o_state), 32'd0);

    // Reload a bare halt word to clear halted, then step
    send_byte(8'h4C);
    chk("reload_halted_clear", 32'(o_halted), 32'd0);
    push(2'd0, HALT);
    send_word(HALT);
    tick(1'b0, 8'h00, 1'b0);
    chk("reload_state", 32'(o_state), 32'd0);
    n_en = 0;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 8'h53, 1'b0);
      tick((k == 1), 8'h43, 1'b0);    // second step gets a 'C' during its pulse
      chk("step_pulse_state", 32'(o_state), 32'd4);
      tick(1'b0, 8'h00, 1'b0);
      chk("step_end_state", 32'(o_state), 32'd0);
      chk("step_end_enable", 32'(o_enable_pipe), 32'd0);
      tick(1'b0, 8'h00, 1'b0);
    end
    chk("step_cycles", 32'(n_en), 32'd3);
    tick(1'b1, 8'h53, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    chk("step_halt_state", 32'(o_state), 32'd4);
    tick(1'b0, 8'h00, 1'b0);
    chk("step_halted", 32'(o_halted), 32'd1);
    send_byte(8'h53);
    tick(1'b0, 8'h00, 1'b0);
    chk("step_after_halt_cycles", 32'(n_en), 32'd4);

    // Overflow: four non-halt words fill memory, the fifth is ignored
    send_byte(8'h4C);
    chk("ovf_clear", 32'(o_overflow), 32'd0);
    for (int i = 3; i < 7; i++) begin
      if (vec[i].wr) push(vec[i].addr, vec[i].word);
      send_word(vec[i].word);
    end
    tick(1'b0, 8'h00, 1'b0);
    chk("ovf_flag", 32'(o_overflow), 32'd1);
    chk("ovf_state", 32'(o_state), 32'd0);
    if (vec[7].wr) push(vec[7].addr, vec[7].word);
    send_word(vec[7].word);
    tick(1'b0, 8'h00, 1'b0);
    chk("ovf_fifth_state", 32'(o_state), 32'd0);
    chk("ovf_writes", 32'(n_wr), 32'd8);

    // Asynchronous reset in the middle of the second word
    send_byte(8'h4C);
    push(2'd0, 32'h1234_5678);
    send_word(32'h1234_5678);
    send_byte(8'hAB);
    send_byte(8'hCD);
    chk("pre_rst_addr", 32'(o_addr_inst_load), 32'd1);
    #2 i_reset = 1'b1;
    i_rx_done = 1'b0;
    #1;
    chk("async_rst_state", 32'(o_state), 32'd0);
    chk("async_rst_debug_unit", 32'(o_debug_unit), 32'd0);
    chk("async_rst_addr", 32'(o_addr_inst_load), 32'd0);
    #1 i_reset = 1'b0;
    send_byte(8'h4C);
    push(2'd0, 32'hAABB_CCDD);
    send_word(32'hAABB_CCDD);
    tick(1'b0, 8'h00, 1'b0);
    chk("post_rst_writes", 32'(n_wr), 32'd10);
    chk("post_rst_state", 32'(o_state), 32'd1);

    // Back-to-back strobes: the fifth byte lands during WRITE
    @(negedge clock); i_reset = 1'b1;
    @(negedge clock); i_reset = 1'b0;
    send_byte(8'h4C);
    push(2'd0, 32'h1122_3344);
    push(2'd1, 32'h5566_7788);
    for (int i = 0; i < 8; i++) tick(1'b1, b2b[i], 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    chk("b2b_writes", 32'(n_wr), 32'd12);
    tick(1'b0, 8'h00, 1'b0);
    chk("b2b_state", 32'(o_state), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
